// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings, widths and score helpers for the LED target game
package game_pkg;

  typedef enum logic [1:0] {
    LVL_SLOW = 2'b00,
    LVL_MED  = 2'b01,
    LVL_FAST = 2'b10,
    LVL_RSVD = 2'b11
  } level_e;

  localparam int IDX_W   = 5;
  localparam int TIMER_W = 6;
  localparam int SCORE_W = 8;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'b0, v[i]};
    return n;
  endfunction

  // One extra bit of headroom catches the carry out; 255 + 32 still fits
  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [5:0] b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + {{(SCORE_W-5){1'b0}}, b};
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

endpackage

// File: rtl/sw_edge_sync.sv
// rtl/sw_edge_sync.sv - two-flop synchroniser with rising-edge detect for raw switches
module sw_edge_sync #(
  parameter int WIDTH = 18
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_rise
);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_rise = r_sync2 & ~r_prev;

endmodule

// File: rtl/led_target_ctrl.sv
// rtl/led_target_ctrl.sv - lights requested LEDs as timed targets and scores hits/expiries
module led_target_ctrl
  import game_pkg::*;
#(
  parameter int LED_COUNT   = 18,
  parameter int TICK_CYCLES = 5_000_000,
  parameter int LIFE0       = 30,
  parameter int LIFE1       = 15,
  parameter int LIFE2       = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clear,
  input  logic [1:0]           i_level,
  input  logic                 i_led_request,
  input  logic [IDX_W-1:0]     i_led_index,
  input  logic [LED_COUNT-1:0] i_sw,
  output logic [LED_COUNT-1:0] o_leds,
  output logic                 o_hit_pulse,
  output logic                 o_miss_pulse,
  output logic                 o_wrong_pulse,
  output logic [SCORE_W-1:0]   o_hit_count,
  output logic [SCORE_W-1:0]   o_miss_count
);

  localparam int PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  logic [PRE_W-1:0]     r_presc;
  logic [LED_COUNT-1:0] r_leds;
  logic [TIMER_W-1:0]   r_timer [LED_COUNT];
  logic                 r_hit_pulse;
  logic                 r_miss_pulse;
  logic                 r_wrong_pulse;
  logic [SCORE_W-1:0]   r_hit_count;
  logic [SCORE_W-1:0]   r_miss_count;

  logic                 w_tick;
  logic [TIMER_W-1:0]   w_life;
  logic [LED_COUNT-1:0] w_rise;
  logic [LED_COUNT-1:0] w_hit;
  logic [LED_COUNT-1:0] w_exp;
  logic [LED_COUNT-1:0] w_wrong;
  logic [LED_COUNT-1:0] w_leds_n;
  logic [TIMER_W-1:0]   w_timer_n [LED_COUNT];

  sw_edge_sync #(
    .WIDTH (LED_COUNT)
  ) u_sw_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_sw),
    .o_rise  (w_rise)
  );

  assign w_tick = (r_presc == PRE_W'(TICK_CYCLES - 1));

  always_comb begin
    case (i_level)
      LVL_MED:  w_life = TIMER_W'(LIFE1);
      LVL_FAST: w_life = TIMER_W'(LIFE2);
      default:  w_life = TIMER_W'(LIFE0);
    endcase
  end

  // All decisions use the pre-edge lit state, so a hit on a lit LED also
  // blocks a same-cycle request to it and always wins over its expiry.
  always_comb begin
    w_leds_n = r_leds;
    w_hit    = '0;
    w_exp    = '0;
    w_wrong  = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      w_timer_n[i] = r_timer[i];
      w_hit[i]     = w_rise[i] & r_leds[i];
      w_wrong[i]   = w_rise[i] & ~r_leds[i];
      w_exp[i]     = w_tick & r_leds[i] & (r_timer[i] == TIMER_W'(1)) & ~w_hit[i];
      if (w_tick && r_leds[i]) w_timer_n[i] = r_timer[i] - TIMER_W'(1);
      if (w_hit[i] || w_exp[i]) w_leds_n[i] = 1'b0;
      if (i_led_request && (i_led_index == IDX_W'(i)) && !r_leds[i]) begin
        w_leds_n[i]  = 1'b1;
        w_timer_n[i] = w_life;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc       <= '0;
      r_leds        <= '0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_wrong_pulse <= 1'b0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
      for (int i = 0; i < LED_COUNT; i++) r_timer[i] <= '0;
    end else if (i_clear) begin
      r_presc       <= '0;
      r_leds        <= '0;
      r_hit_pulse   <= 1'b0;
      r_miss_pulse  <= 1'b0;
      r_wrong_pulse <= 1'b0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
      for (int i = 0; i < LED_COUNT; i++) r_timer[i] <= '0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + PRE_W'(1);
      r_leds        <= w_leds_n;
      r_hit_pulse   <= |w_hit;
      r_miss_pulse  <= |w_exp;
      r_wrong_pulse <= |w_wrong;
      r_hit_count   <= sat_add(r_hit_count, popcount32(32'(w_hit)));
      r_miss_count  <= sat_add(r_miss_count, popcount32(32'(w_exp)));
      for (int i = 0; i < LED_COUNT; i++) r_timer[i] <= w_timer_n[i];
    end
  end

  assign o_leds        = r_leds;
  assign o_hit_pulse   = r_hit_pulse;
  assign o_miss_pulse  = r_miss_pulse;
  assign o_wrong_pulse = r_wrong_pulse;
  assign o_hit_count   = r_hit_count;
  assign o_miss_count  = r_miss_count;

endmodule

// File: tb/tb_led_target_ctrl.sv
// tb/tb_led_target_ctrl.sv - scoreboard bench for led_target_ctrl with a deadline-based reference model
module tb_led_target_ctrl;

  localparam int N    = 18;
  localparam int TICK = 4;
  localparam int L0   = 3;
  localparam int L1   = 2;
  localparam int L2   = 2;

  typedef struct packed {
    logic [N-1:0] leds;
    logic         hp;
    logic         mp;
    logic         wp;
    logic [7:0]   hc;
    logic [7:0]   mc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic [1:0]   level = 2'b00;
  logic         led_request = 1'b0;
  logic [4:0]   led_index = '0;
  logic [N-1:0] sw = '0;
  logic [N-1:0] o_leds;
  logic         o_hit_pulse, o_miss_pulse, o_wrong_pulse;
  logic [7:0]   o_hit_count, o_miss_count;

  led_target_ctrl #(
    .LED_COUNT   (N),
    .TICK_CYCLES (TICK),
    .LIFE0       (L0),
    .LIFE1       (L1),
    .LIFE2       (L2)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_clear       (clear),
    .i_level       (level),
    .i_led_request (led_request),
    .i_led_index   (led_index),
    .i_sw          (sw),
    .o_leds        (o_leds),
    .o_hit_pulse   (o_hit_pulse),
    .o_miss_pulse  (o_miss_pulse),
    .o_wrong_pulse (o_wrong_pulse),
    .o_hit_count   (o_hit_count),
    .o_miss_count  (o_miss_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  exp_t m_e;

  // Reference model: each lit LED remembers the absolute tick number it dies on.
  logic [N-1:0] m_lit, h1, h2, h3;
  int m_dl [N];
  int m_cyc, m_nt, m_hit, m_miss;
  logic [N-1:0] d_sw;
  logic [1:0]   d_level;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int life_of(input logic [1:0] lv);
    if (lv == 2'b01) return L1;
    if (lv == 2'b10) return L2;
    return L0;
  endfunction

  task automatic model_reset();
    m_lit = '0; h1 = '0; h2 = '0; h3 = '0;
    m_cyc = 0; m_nt = 0; m_hit = 0; m_miss = 0;
    for (int i = 0; i < N; i++) m_dl[i] = 0;
  endtask

  task automatic model_step(input logic r, input logic clr, input logic [1:0] lv,
                            input logic req, input logic [4:0] idx, input logic [N-1:0] s);
    exp_t e;
    logic [N-1:0] rise, pre;
    int nh, nm, ii;
    logic tk, wr;
    e = '0;
    if (r) begin
      model_reset();
    end else begin
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = s;
      if (clr) begin
        m_lit = '0; m_hit = 0; m_miss = 0; m_cyc = 0;
      end else begin
        tk = ((m_cyc % TICK) == TICK - 1);
        m_cyc++;
        if (tk) m_nt++;
        pre = m_lit; nh = 0; nm = 0; wr = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (rise[i] && pre[i]) begin nh++; m_lit[i] = 1'b0; end
          else if (rise[i]) wr = 1'b1;
          else if (tk && pre[i] && m_dl[i] == m_nt) begin nm++; m_lit[i] = 1'b0; end
        end
        ii = int'(idx);
        if (req && ii < N) begin
          if (!pre[ii]) begin m_lit[ii] = 1'b1; m_dl[ii] = m_nt + life_of(lv); end
        end
        m_hit  = (m_hit + nh > 255) ? 255 : m_hit + nh;
        m_miss = (m_miss + nm > 255) ? 255 : m_miss + nm;
        e.hp = (nh > 0); e.mp = (nm > 0); e.wp = wr;
      end
      e.leds = m_lit; e.hc = 8'(m_hit); e.mc = 8'(m_miss);
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic req, input logic [4:0] idx, input logic clr);
    @(posedge clk); #2;
    rst = 1'b0; clear = clr; led_request = req; led_index = idx;
    level = d_level; sw = d_sw;
    model_step(1'b0, clr, d_level, req, idx, d_sw);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd0, 1'b0);
  endtask

  task automatic hit_round(input int k);
    for (int j = 0; j < k; j++) drive(1'b1, 5'(j + 1), 1'b0);
    for (int j = 0; j < k; j++) d_sw[j + 1] = 1'b1;
    idle(4);
    d_sw = '0;
    idle(3);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      chk("leds", 32'(o_leds), 32'(m_e.leds));
      chk("hit_pulse", 32'(o_hit_pulse), 32'(m_e.hp));
      chk("miss_pulse", 32'(o_miss_pulse), 32'(m_e.mp));
      chk("wrong_pulse", 32'(o_wrong_pulse), 32'(m_e.wp));
      chk("hit_count", 32'(o_hit_count), 32'(m_e.hc));
      chk("miss_count", 32'(o_miss_count), 32'(m_e.mc));
    end
  end

  initial begin
    bit found;
    int guard;
    model_reset();
    d_sw = '0; d_level = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_leds", 32'(o_leds), 32'h0);
    chk("reset_pulses", {29'b0, o_hit_pulse, o_miss_pulse, o_wrong_pulse}, 32'h0);
    chk("reset_counts", {16'b0, o_hit_count, o_miss_count}, 32'h0);

    // lifetime expiry, hit, wrong press, re-request of a lit LED
    drive(1'b1, 5'd5, 1'b0); idle(16);
    drive(1'b1, 5'd7, 1'b0); idle(1);
    d_sw[7] = 1'b1; idle(5); d_sw[7] = 1'b0; idle(3);
    d_sw[3] = 1'b1; idle(5); d_sw[3] = 1'b0; idle(3);
    drive(1'b1, 5'd3, 1'b0); idle(3); drive(1'b1, 5'd3, 1'b0); idle(16);

    // out-of-range index, simultaneous double hit
    drive(1'b1, 5'd20, 1'b0); idle(2);
    drive(1'b1, 5'd0, 1'b0); drive(1'b1, 5'd17, 1'b0);
    d_sw[0] = 1'b1; d_sw[17] = 1'b1; idle(5); d_sw = '0; idle(3);

    // hit landing on the very tick that would expire LED 2
    drive(1'b1, 5'd2, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (m_lit[2] && ((m_cyc + 2) % TICK == TICK - 1) && (m_nt + 1 == m_dl[2])) found = 1'b1;
      else idle(1);
    end
    n_cmp++;
    if (!found) begin n_bad++; $display("FAIL hit_on_expiry_setup: got 0 expected 1"); end
    d_sw[2] = 1'b1; idle(4); d_sw[2] = 1'b0; idle(3);

    // drive hit_count to 254, then a three-way hit saturates it
    guard = 0;
    while (m_hit < 249 && guard < 200) begin hit_round(5); guard++; end
    while (m_hit < 254 && guard < 260) begin
      hit_round((254 - m_hit > 5) ? 5 : 254 - m_hit); guard++;
    end
    hit_round(3);
    chk("hit_saturated", 32'(o_hit_count), 32'd255);

    // asynchronous reset mid-clock with four LEDs lit
    drive(1'b1, 5'd4, 1'b0); drive(1'b1, 5'd6, 1'b0);
    drive(1'b1, 5'd8, 1'b0); drive(1'b1, 5'd11, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1; led_request = 1'b0; clear = 1'b0;
    #1;
    chk("async_rst_leds", 32'(o_leds), 32'h0);
    chk("async_rst_hit_count", 32'(o_hit_count), 32'h0);
    model_step(1'b1, 1'b0, d_level, 1'b0, 5'd0, d_sw);
    idle(2);

    // synchronous clear drops a same-cycle request
    drive(1'b1, 5'd10, 1'b0); drive(1'b1, 5'd12, 1'b0);
    drive(1'b1, 5'd13, 1'b0); drive(1'b1, 5'd14, 1'b0);
    d_sw[10] = 1'b1; idle(4); d_sw[10] = 1'b0;
    drive(1'b1, 5'd9, 1'b1); idle(4);

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3, 0) == 0) d_sw[$urandom_range(N - 1, 0)] ^= 1'b1;
      if ($urandom_range(15, 0) == 0) d_level = 2'($urandom_range(3, 0));
      drive($urandom_range(2, 0) == 0, 5'($urandom_range(23, 0)), $urandom_range(99, 0) == 0);
    end
    d_sw = '0; idle(8);

    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/led_target_ctrl.md
Name: led_target_ctrl

Overview:
- Consumer end of the random-LED request interface: accepts one-cycle led_request pulses carrying led_index and lights that LED as a live target.
- Expires each target after a level-dependent lifetime, and clears it when the player raises the matching switch.
- Reports hits, timeouts and wrong presses as pulses and saturating counts for the score/display logic.
- Sits between the random LED generator and the LEDR outputs / scoring block.

Parameters:
- LED_COUNT, 18, number of LEDs/switches (max 32).
- TICK_CYCLES, 5_000_000, clk cycles per lifetime tick (0.1 s at 50 MHz).
- LIFE0, 30, lifetime in ticks at level 2'b00 (range 2..63).
- LIFE1, 15, lifetime in ticks at level 2'b01.
- LIFE2, 8, lifetime in ticks at level 2'b10. Level 2'b11 uses LIFE0.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous game restart: clears all targets, counts and the prescaler.
- level  input  2  difficulty, same encoding as the generator.
- led_request  input  1  one-cycle request pulse.
- led_index  input  5  LED to light; valid only when led_request=1.
- sw  input  LED_COUNT  raw player switches, asynchronous to clk.
- leds  output  LED_COUNT  live targets, registered.
- hit_pulse  output  1  one cycle: at least one target hit this cycle.
- miss_pulse  output  1  one cycle: at least one target expired this cycle.
- wrong_pulse  output  1  one cycle: a rising switch on an unlit LED.
- hit_count  output  8  total hits, saturates at 255.
- miss_count  output  8  total expiries, saturates at 255.

Behaviour:
- Reset values: leds, all timers, prescaler, pulses and counts = 0. Reset is valid mid-game and drops all targets immediately. clear has the same effect synchronously and takes priority over every other event in its cycle.
- Switch path: sw passes through a 2-flop synchroniser plus a previous-value register. A rising edge (sync2 & ~prev) is acted on at the 3rd rising clk edge after sw settles. Falling edges are ignored.
- Prescaler: counts 0..TICK_CYCLES-1. tick=1 when it equals TICK_CYCLES-1, then it wraps to 0. It free-runs and is independent of requests.
- Per-LED state: lit bit (leds[i]) and a 6-bit down-counter timer[i].
- Request: on led_request with led_index < LED_COUNT and leds[idx]=0, set leds[idx] and load timer[idx] from the level's LIFE value. Level is sampled at that cycle; later level changes do not affect targets already lit. Requests to an already-lit LED, or with idx >= LED_COUNT, are ignored (no timer reload). leds updates on the edge where led_request is sampled, so latency is 1 cycle.
- Tick: for every lit LED, timer decrements. If timer==1 on a tick, the LED clears and counts as an expiry. Effective lifetime is LIFE-1 to LIFE ticks.
- Hit: a rising edge on sw[i] with leds[i]=1 clears the LED and counts as a hit. A rising edge with leds[i]=0 asserts wrong_pulse. Count deltas are not recorded for wrong presses.
- Same-cycle priority per LED, evaluated on the pre-edge state:
  - hit beats expiry;
  - hit on a lit LED blocks a same-cycle request to that index;
  - rising sw on an unlit LED plus a request to it gives wrong_pulse, and the LED lights.
- Counts: hit_count += popcount(hits this cycle) and miss_count += popcount(expiries this cycle), with 9-bit intermediate math saturating at 255.
- Pulses are registered: asserted the cycle after the event edge, for exactly one cycle even when several LEDs are involved.

Decomposition:
- Shared package game_pkg holds:
  - level encodings LVL_SLOW=2'b00, LVL_MED=2'b01, LVL_FAST=2'b10;
  - IDX_W=5 and TIMER_W=6;
  - SCORE_W=8.
- One sub-module, sw_edge_sync (parameter WIDTH): 2-flop synchroniser plus rising-edge detector, reset to 0. The generator's level encoding is imported from the same package.

Test Plan (bench uses TICK_CYCLES=4, LIFE0=3, LIFE1=2, LIFE2=2):
- Reset, then request idx=5, level=00 → leds=18'h00020 next cycle. After 3 ticks leds=0, one miss_pulse, miss_count=1.
- Request idx=7, then raise sw[7] → leds[7] clears 3 clk edges later, hit_pulse for 1 cycle, hit_count=1, miss_count unchanged.
- Raise sw[3] with LED 3 unlit → wrong_pulse=1 for one cycle, counts unchanged. Request idx=3 while already lit → timer not reloaded, expiry on the original schedule.
- Request idx=20 → ignored, leds=0. Request idx=0 and idx=17 on consecutive cycles, both hit in the same cycle → hit_count +2, single hit_pulse.
- Hit on LED 2 in the same cycle its timer hits 1 on a tick → counted as hit, miss_count unchanged. Preload hit_count=254 via 3 hits in one cycle → saturates at 255.
- Assert rst asynchronously (mid-clock) with 4 LEDs lit → leds=0 immediately. Same setup with clear → leds, counts = 0 next edge, and a request in the clear cycle is dropped.
